aura_mem_ctrl: RTL



---
 rtl/aura_mem_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/aura_mem_ctrl.sv
// AURA memory front end: bursts row loads as tagged 64-bit LOADs, reorders returns
// into address order for the consumer, and forwards single-line stores.
module aura_mem_ctrl #(
    parameter int unsigned LINES_PER_ROW = 8,
    parameter int unsigned NUM_TAGS      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic [31:0] rd_req_addr,
    output logic        rd_data_valid,
    input  logic        rd_data_ready,
    output logic [63:0] rd_data,
    output logic        rd_data_last,
    input  logic        wr_req_valid,
    output logic        wr_req_ready,
    input  logic [31:0] wr_addr,
    input  logic [63:0] wr_data,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    input  logic [3:0]  mem2proc_transaction_tag,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_data_tag,
    output logic        idle
);
    localparam int unsigned SLOT_W = (LINES_PER_ROW > 1) ? $clog2(LINES_PER_ROW) : 1;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned TAG_N  = 1 << TAG_W;
    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_LOAD  = 2'd1;
    localparam logic [1:0] CMD_STORE = 2'd2;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LINES_PER_ROW - 1);

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} r_state_t;

    r_state_t          state;
    r_state_t          state_nxt;
    logic [31:0]       base;
    logic [SLOT_W-1:0] issue_cnt;
    logic [SLOT_W-1:0] drain_cnt;
    logic [TAG_N-1:0]  tag_valid;
    logic [SLOT_W-1:0] tag_slot [TAG_N];
    logic [63:0]       line_buf [LINES_PER_ROW];
    logic [LINES_PER_ROW-1:0] slot_valid;

    logic              load_accept;
    logic              drain_hs;
    logic              ret_hit;
    logic [SLOT_W-1:0] ret_slot;

    // Consumer side reads the slot at the head of the row
    assign rd_data_valid = slot_valid[drain_cnt];
    assign rd_data       = line_buf[drain_cnt];
    assign rd_data_last  = (drain_cnt == LAST_SLOT);
    assign drain_hs      = rd_data_valid && rd_data_ready;
    assign idle          = (state == R_IDLE) && (tag_valid == '0);

    // Returns for tags not in the table (store tags, stale tags) are dropped
    assign ret_hit  = (mem2proc_data_tag != '0) && (32'(mem2proc_data_tag) <= NUM_TAGS)
                      && tag_valid[mem2proc_data_tag];
    assign ret_slot = tag_slot[mem2proc_data_tag];

    always_ff @(posedge clk) begin
        if (rst) state <= R_IDLE;
        else     state <= state_nxt;
    end

    // Next state and memory command; a pending store pre-empts the load for one cycle
    always_comb begin
        state_nxt        = state;
        rd_req_ready     = 1'b0;
        proc2mem_command = CMD_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        load_accept      = 1'b0;
        wr_req_ready     = wr_req_valid && (mem2proc_transaction_tag != '0);
        if (wr_req_valid) begin
            proc2mem_command = CMD_STORE;
            proc2mem_addr    = wr_addr;
            proc2mem_data    = wr_data;
        end
        case (state)
            R_IDLE: begin
                rd_req_ready = 1'b1;
                if (rd_req_valid) state_nxt = R_ISSUE;
            end
            R_ISSUE: begin
                if (!wr_req_valid) begin
                    proc2mem_command = CMD_LOAD;
                    proc2mem_addr    = base + 32'({issue_cnt, 3'b000});
                    load_accept      = (mem2proc_transaction_tag != '0);
                    if (load_accept && (issue_cnt == LAST_SLOT)) state_nxt = R_DRAIN;
                end
            end
            R_DRAIN: begin
                if (drain_hs && (drain_cnt == LAST_SLOT)) state_nxt = R_IDLE;
            end
            default: state_nxt = R_IDLE;
        endcase
    end

    // Tag table, reorder buffer and row counters
    always_ff @(posedge clk) begin
        if (rst) begin
            base       <= '0;
            issue_cnt  <= '0;
            drain_cnt  <= '0;
            tag_valid  <= '0;
            slot_valid <= '0;
            for (int i = 0; i < int'(TAG_N); i++) tag_slot[i] <= '0;
            for (int i = 0; i < int'(LINES_PER_ROW); i++) line_buf[i] <= '0;
        end else begin
            if (rd_req_valid && rd_req_ready) begin
                base       <= rd_req_addr;
                issue_cnt  <= '0;
                drain_cnt  <= '0;
                slot_valid <= '0;
            end else begin
                if (drain_hs) begin
                    slot_valid[drain_cnt] <= 1'b0;
                    drain_cnt             <= drain_cnt + SLOT_W'(1);
                end
                if (ret_hit) begin
                    line_buf[ret_slot]   <= mem2proc_data;
                    slot_valid[ret_slot] <= 1'b1;
                end
                if (load_accept) issue_cnt <= issue_cnt + SLOT_W'(1);
            end
            // Return clears first so a same-cycle re-grant of that tag wins
            if (ret_hit) tag_valid[mem2proc_data_tag] <= 1'b0;
            if (load_accept) begin
                tag_valid[mem2proc_transaction_tag] <= 1'b1;
                tag_slot[mem2proc_transaction_tag]  <= issue_cnt;
            end
        end
    end
endmodule
